// File: rtl/sifh_peak_reader_if.sv
// Peak-result stream between the SiFH peak reader and the TOF back end.
//   peak_valid  result valid (driven by master)
//   peak_ready  result accepted when valid & ready (driven by slave)
//   peak_pixel  pixel index of result
//   peak_bin    bin index holding the maximum count
//   peak_count  maximum count value
interface sifh_peak_reader_if #(
    parameter int unsigned PIX_W = 2,
    parameter int unsigned NB_W  = 4,
    parameter int unsigned CNT_W = 8
);
    logic             peak_valid;
    logic             peak_ready;
    logic [PIX_W-1:0] peak_pixel;
    logic [NB_W-1:0]  peak_bin;
    logic [CNT_W-1:0] peak_count;

    modport master (
        output peak_valid,
        output peak_pixel,
        output peak_bin,
        output peak_count,
        input  peak_ready
    );

    modport slave (
        input  peak_valid,
        input  peak_pixel,
        input  peak_bin,
        input  peak_count,
        output peak_ready
    );
endinterface

// File: rtl/sifh_peak_reader.sv
// SiFH histogram peak reader.
// After accumulation, scans the histogram RAM one pixel at a time on port B,
// finds the peak bin of each pixel (ties go to the lowest bin) and streams
// {pixel, bin, count} over the pk interface. With CLEAR_EN=1 every word is
// zeroed on port A one cycle after it was read.
// Ports:
//   clk, res      clock, synchronous active-low reset
//   start         1-cycle pulse, begins a scan when idle
//   busy          high while a scan is in progress
//   raddr/rEnable RAM port B address / read enable
//   counts        RAM port B data, one cycle after the read
//   waddr/wEnable RAM port A address / write enable
//   newCounts     RAM port A data, always zero
//   done          1-cycle pulse after the last result is accepted
//   pk            peak result stream (master side)
module sifh_peak_reader #(
    parameter int unsigned NB_W     = 4,
    parameter int unsigned PIX_W    = 2,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned ADDR_W   = NB_W + PIX_W,
    parameter int unsigned CLEAR_EN = 1
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    output logic                 busy,
    output logic [ADDR_W-1:0]    raddr,
    output logic                 rEnable,
    input  logic [CNT_W-1:0]     counts,
    output logic [ADDR_W-1:0]    waddr,
    output logic                 wEnable,
    output logic [CNT_W-1:0]     newCounts,
    output logic                 done,
    sifh_peak_reader_if.master   pk
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        EMIT,
        DONE
    } state_t;

    state_t             state_q, state_n;

    logic [NB_W-1:0]    bin_q;
    logic [PIX_W-1:0]   pix_q;
    logic               rd_q;
    logic               cmp_vld_q;
    logic [NB_W-1:0]    cmp_bin_q;
    logic [CNT_W-1:0]   max_cnt_q;
    logic [NB_W-1:0]    max_bin_q;
    logic               wen_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic               valid_q;
    logic [PIX_W-1:0]   peak_pix_q;
    logic [NB_W-1:0]    peak_bin_q;
    logic [CNT_W-1:0]   peak_cnt_q;
    logic               busy_q;
    logic               done_q;

    logic               take;
    logic [CNT_W-1:0]   nxt_cnt;
    logic [NB_W-1:0]    nxt_bin;
    logic               accept;

    always_comb begin
        state_n = state_q;
        take    = 1'b0;
        nxt_cnt = max_cnt_q;
        nxt_bin = max_bin_q;
        accept  = 1'b0;

        // Bin 0 loads unconditionally; later bins only on a strict increase,
        // so ties keep the lowest bin index.
        if (cmp_vld_q && ((cmp_bin_q == '0) || (counts > max_cnt_q))) begin
            take    = 1'b1;
            nxt_cnt = counts;
            nxt_bin = cmp_bin_q;
        end

        case (state_q)
            IDLE: begin
                if (start) state_n = READ;
            end
            READ: begin
                if (bin_q == '1) state_n = DRAIN;
            end
            DRAIN: begin
                state_n = EMIT;
            end
            EMIT: begin
                if (pk.peak_ready) begin
                    accept  = 1'b1;
                    state_n = (pix_q == '1) ? DONE : READ;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            pix_q      <= '0;
            rd_q       <= 1'b0;
            cmp_vld_q  <= 1'b0;
            cmp_bin_q  <= '0;
            max_cnt_q  <= '0;
            max_bin_q  <= '0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            valid_q    <= 1'b0;
            peak_pix_q <= '0;
            peak_bin_q <= '0;
            peak_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_n;

            // bin_q wraps to 0 on the last read, ready for the next pixel.
            if (state_q == READ) bin_q <= bin_q + NB_W'(1);
            if (accept)          pix_q <= pix_q + PIX_W'(1);

            rd_q      <= (state_n == READ);
            cmp_vld_q <= rd_q;
            cmp_bin_q <= bin_q;

            if (take) begin
                max_cnt_q <= nxt_cnt;
                max_bin_q <= nxt_bin;
            end

            // Clear the word compared this cycle, i.e. the one read last cycle.
            wen_q   <= (CLEAR_EN != 0) && rd_q;
            waddr_q <= raddr;

            // DRAIN resolves the final bin; capture the resolved maximum.
            if (state_q == DRAIN) begin
                peak_pix_q <= pix_q;
                peak_bin_q <= nxt_bin;
                peak_cnt_q <= nxt_cnt;
            end

            valid_q <= (state_n == EMIT);
            busy_q  <= (state_n != IDLE);
            done_q  <= (state_n == DONE);
        end
    end

    assign raddr         = ADDR_W'({pix_q, bin_q});
    assign rEnable       = rd_q;
    assign waddr         = waddr_q;
    assign wEnable       = wen_q;
    assign newCounts     = '0;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pk.peak_valid = valid_q;
    assign pk.peak_pixel = peak_pix_q;
    assign pk.peak_bin   = peak_bin_q;
    assign pk.peak_count = peak_cnt_q;

endmodule

// File: tb/tb_sifh_peak_reader.sv
// Directed bench for sifh_peak_reader: one clearing and one non-clearing
// instance share stimulus, each with its own synchronous-read RAM model.
module tb_sifh_peak_reader;

    typedef struct packed {
        logic [1:0] pix;
        logic [3:0] bin;
        logic [7:0] cnt;
    } res_t;

    logic       clk;
    logic       res;
    logic       start;
    logic       ready;
    logic       load;
    int         sel;

    logic       busy, rEnable, wEnable, done;
    logic [5:0] raddr, waddr;
    logic [7:0] counts, newCounts;
    logic       busy0, rEnable0, wEnable0, done0;
    logic [5:0] raddr0, waddr0;
    logic [7:0] counts0, newCounts0;

    logic [7:0] mem  [64];
    logic [7:0] mem0 [64];

    int nerr = 0;
    int nchk = 0;
    int cyc  = 0;

    res_t q[$];
    res_t q0[$];
    int   vq[$];
    int   dq[$];
    int   wcnt = 0;
    int   w0cnt = 0;
    logic prev_vld = 1'b0;
    logic prev_ren = 1'b0;
    logic [5:0] prev_raddr = '0;

    sifh_peak_reader_if #(.PIX_W(2), .NB_W(4), .CNT_W(8)) pk ();
    sifh_peak_reader_if #(.PIX_W(2), .NB_W(4), .CNT_W(8)) pk0 ();

    assign pk.peak_ready  = ready;
    assign pk0.peak_ready = ready;

    sifh_peak_reader #(.NB_W(4), .PIX_W(2), .CNT_W(8), .CLEAR_EN(1)) dut (
        .clk(clk), .res(res), .start(start), .busy(busy),
        .raddr(raddr), .rEnable(rEnable), .counts(counts),
        .waddr(waddr), .wEnable(wEnable), .newCounts(newCounts),
        .done(done), .pk(pk)
    );

    sifh_peak_reader #(.NB_W(4), .PIX_W(2), .CNT_W(8), .CLEAR_EN(0)) dut0 (
        .clk(clk), .res(res), .start(start), .busy(busy0),
        .raddr(raddr0), .rEnable(rEnable0), .counts(counts0),
        .waddr(waddr0), .wEnable(wEnable0), .newCounts(newCounts0),
        .done(done0), .pk(pk0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Histogram images: 0 = flat 3s, 1 = peak/tie/zero/saturation, 2 = per-pixel peaks.
    function automatic logic [7:0] img(input int s, input int a);
        int p = a >> 4;
        int b = a & 15;
        case (s)
            1: begin
                case (p)
                    0:       return (b == 4 || b == 11) ? 8'd57 : 8'd3;
                    1:       return 8'd0;
                    2:       return (b == 9) ? 8'd200 : 8'd3;
                    default: return (b == 15) ? 8'd255 : 8'd3;
                endcase
            end
            2:       return (b == 3 * p + 1) ? 8'(100 + p) : 8'd1;
            default: return 8'd3;
        endcase
    endfunction

    function automatic int exp_bin(input int s, input int p);
        if (s == 1) begin
            case (p)
                0: return 4;
                1: return 0;
                2: return 9;
                default: return 15;
            endcase
        end
        return 3 * p + 1;
    endfunction

    function automatic int exp_cnt(input int s, input int p);
        if (s == 1) begin
            case (p)
                0: return 57;
                1: return 0;
                2: return 200;
                default: return 255;
            endcase
        end
        return 100 + p;
    endfunction

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 64; i++) begin
                mem[i]  <= img(sel, i);
                mem0[i] <= img(sel, i);
            end
        end else begin
            if (rEnable)  counts       <= mem[raddr];
            if (wEnable)  mem[waddr]   <= newCounts;
            if (rEnable0) counts0      <= mem0[raddr0];
            if (wEnable0) mem0[waddr0] <= newCounts0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor at the falling edge: results, valid rises, done pulses, write timing.
    always @(negedge clk) begin
        if (pk.peak_valid && pk.peak_ready)
            q.push_back({pk.peak_pixel, pk.peak_bin, pk.peak_count});
        if (pk0.peak_valid && pk0.peak_ready)
            q0.push_back({pk0.peak_pixel, pk0.peak_bin, pk0.peak_count});
        if (pk.peak_valid && !prev_vld) vq.push_back(cyc);
        prev_vld = pk.peak_valid;
        if (done) dq.push_back(cyc);
        if (wEnable) begin
            wcnt++;
            chk("w_trails_r", 32'({prev_ren, prev_raddr}), 32'({1'b1, waddr}));
            if (rEnable) chk("w_r_collide", 32'(waddr == raddr), 0);
        end
        if (wEnable0) w0cnt++;
        prev_ren   = rEnable;
        prev_raddr = raddr;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_img(input int s);
        sel  = s;
        load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    task automatic pulse_start(output int t0);
        t0    = cyc;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 120; i++) begin
            if (done) break;
            tick(1);
        end
        if (i == 120) chk(tag, 0, 1);
    endtask

    task automatic check_res(input int s, input int qb, input int q0b);
        res_t r;
        chk("n_res", 32'(q.size() - qb), 4);
        chk("n_res0", 32'(q0.size() - q0b), 4);
        for (int i = 0; i < 4; i++) begin
            if (qb + i < q.size()) begin
                r = q[qb + i];
                chk("res_pix", 32'(r.pix), 32'(i));
                chk("res_bin", 32'(r.bin), 32'(exp_bin(s, i)));
                chk("res_cnt", 32'(r.cnt), 32'(exp_cnt(s, i)));
            end
            if (q0b + i < q0.size()) begin
                r = q0[q0b + i];
                chk("res0_bin", 32'(r.bin), 32'(exp_bin(s, i)));
                chk("res0_cnt", 32'(r.cnt), 32'(exp_cnt(s, i)));
            end
        end
    endtask

    function automatic logic [30:0] outs();
        return {busy, rEnable, raddr, wEnable, waddr, pk.peak_valid,
                pk.peak_pixel, pk.peak_bin, pk.peak_count, done};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, qb, q0b, vb, db, wb, w0b, nz, diff;
        logic [1:0] cp;
        logic [3:0] cb;
        logic [7:0] cc;

        res = 1'b0; start = 1'b0; ready = 1'b1; load = 1'b0; sel = 0;
        tick(3);
        chk("reset_outs", 32'(outs()), 0);
        chk("reset_newcounts", 32'(newCounts), 0);
        res = 1'b1;
        load_img(0);
        tick(1);
        chk("idle_busy", 32'(busy), 0);

        // Reset in the middle of READ aborts the scan.
        db = dq.size();
        pulse_start(t0);
        tick(4);
        chk("midscan_ren", 32'(rEnable), 1);
        res = 1'b0;
        tick(2);
        chk("midscan_reset_outs", 32'(outs()), 0);
        res = 1'b1;
        tick(5);
        chk("post_reset_busy", 32'(busy), 0);
        chk("post_reset_no_done", 32'(dq.size() - db), 0);

        // Full scan, ready high, with ignored start pulses.
        load_img(1);
        tick(1);
        qb = q.size(); q0b = q0.size(); vb = vq.size(); db = dq.size();
        wb = wcnt; w0b = w0cnt;
        pulse_start(t0);
        chk("c1_busy", 32'(busy), 1);
        chk("c1_read", 32'({rEnable, raddr}), 32'({1'b1, 6'd0}));
        tick(29);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done("done_timeout_scan");
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("after_done_busy", 32'(busy), 0);
        chk("after_done_done", 32'(done), 0);
        tick(2);
        chk("ignored_start_busy", 32'({busy, rEnable}), 0);
        if (vq.size() > vb) chk("first_valid_cyc", 32'(vq[vb] - t0), 18);
        else                chk("first_valid_seen", 0, 1);
        chk("n_done", 32'(dq.size() - db), 1);
        if (dq.size() > db) chk("done_cyc", 32'(dq[db] - t0), 73);
        check_res(1, qb, q0b);
        chk("clear_writes", 32'(wcnt - wb), 64);
        chk("noclear_writes", 32'(w0cnt - w0b), 0);
        nz = 0; diff = 0;
        for (int i = 0; i < 64; i++) begin
            if (mem[i] != 8'd0) nz++;
            if (mem0[i] != img(1, i)) diff++;
        end
        chk("ram_cleared", 32'(nz), 0);
        chk("ram_untouched", 32'(diff), 0);

        // Backpressure: hold off the first result for 5 cycles.
        load_img(2);
        tick(1);
        ready = 1'b0;
        qb = q.size(); q0b = q0.size(); db = dq.size();
        pulse_start(t0);
        for (int i = 0; i < 40; i++) begin
            if (pk.peak_valid) break;
            tick(1);
        end
        chk("bp_valid_cyc", 32'(cyc - t0), 18);
        cp = pk.peak_pixel; cb = pk.peak_bin; cc = pk.peak_count;
        chk("bp_first", 32'({cp, cb, cc}), 32'({2'd0, 4'd1, 8'd100}));
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("bp_hold", 32'({pk.peak_valid, pk.peak_pixel, pk.peak_bin, pk.peak_count}),
                32'({1'b1, cp, cb, cc}));
            chk("bp_no_ram", 32'({rEnable, wEnable}), 0);
        end
        ready = 1'b1;
        wait_done("done_timeout_bp");
        tick(2);
        chk("bp_n_done", 32'(dq.size() - db), 1);
        if (dq.size() > db) chk("bp_done_cyc", 32'(dq[db] - t0), 78);
        check_res(2, qb, q0b);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
